// File: rtl/bfly_operand_loader.sv
// Fetches the four SRAM words of one radix-2 butterfly (A re/im, B re/im) and hands them over with valid/ready.
// Optional statistics outputs (sets_done, stray_rvalid) are built when BFLY_LOADER_STATS_EN is defined.
module bfly_operand_loader #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rvalid,
  output logic [2:0]        samples_loaded_count,
  output logic              read_req,
  output logic              busy,
  output logic              ops_valid,
  input  logic              ops_ready,
  output logic [DATA_W-1:0] a_real,
  output logic [DATA_W-1:0] a_imag,
  output logic [DATA_W-1:0] b_real,
  output logic [DATA_W-1:0] b_imag
`ifdef BFLY_LOADER_STATS_EN
  ,
  output logic [15:0]       sets_done,
  output logic              stray_rvalid
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] count_next;
  logic       capture;

  always_comb begin
    state_next = state;
    count_next = samples_loaded_count;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADDR;
          count_next = 3'd0;
        end else begin
          count_next = 3'd4;
        end
      end
      // ADDR only gives the downstream address register a cycle to load.
      ADDR: state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: begin
        if (sram_rvalid) begin
          capture = 1'b1;
          if (samples_loaded_count == 3'd3) begin
            state_next = HOLD;
            count_next = 3'd4;
          end else begin
            state_next = ADDR;
            count_next = samples_loaded_count + 3'd1;
          end
        end
      end
      HOLD: begin
        if (ops_ready) begin
          if (start) begin
            state_next = ADDR;
            count_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 3'd4;
      end
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                <= IDLE;
      samples_loaded_count <= 3'd4;
      read_req             <= 1'b0;
      busy                 <= 1'b0;
      ops_valid            <= 1'b0;
      a_real               <= '0;
      a_imag               <= '0;
      b_real               <= '0;
      b_imag               <= '0;
    end else begin
      state                <= state_next;
      samples_loaded_count <= count_next;
      read_req             <= (state_next == REQ);
      busy                 <= (state_next != IDLE);
      ops_valid            <= (state_next == HOLD);
      if (capture) begin
        case (samples_loaded_count[1:0])
          2'd0:    a_real <= sram_rdata;
          2'd1:    a_imag <= sram_rdata;
          2'd2:    b_real <= sram_rdata;
          default: b_imag <= sram_rdata;
        endcase
      end
    end
  end

`ifdef BFLY_LOADER_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sets_done    <= 16'd0;
      stray_rvalid <= 1'b0;
    end else begin
      if (state == HOLD && ops_ready) begin
        sets_done <= sets_done + 16'd1;
      end
      if (sram_rvalid && state != WAIT) begin
        stray_rvalid <= 1'b1;
      end
    end
  end
`endif

  count_in_range: assert property (@(posedge clk) disable iff (!nrst) samples_loaded_count <= 3'd4);

endmodule

// File: tb/tb_bfly_operand_loader.sv
// Scoreboard bench for bfly_operand_loader: a latency-randomised SRAM responder feeds words, a monitor checks each handshake.
// Statistics checks are compiled in when BFLY_LOADER_STATS_EN is defined.
module tb_bfly_operand_loader;
  localparam int DW = 16;
  typedef logic [3:0][DW-1:0] set_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          ops_ready = 1'b0;
  logic          resp_valid = 1'b0;
  logic          stray_valid = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic          sram_rvalid;
  logic [DW-1:0] sram_rdata;
  logic [2:0]    samples_loaded_count;
  logic          read_req, busy, ops_valid;
  logic [DW-1:0] a_real, a_imag, b_real, b_imag;
`ifdef BFLY_LOADER_STATS_EN
  logic [15:0]   sets_done;
  logic          stray_rvalid;
`endif

  assign sram_rvalid = resp_valid | stray_valid;
  assign sram_rdata  = stray_valid ? 16'hDEAD : resp_data;

  bfly_operand_loader #(.DATA_W(DW)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid),
    .samples_loaded_count(samples_loaded_count), .read_req(read_req),
    .busy(busy), .ops_valid(ops_valid), .ops_ready(ops_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag)
`ifdef BFLY_LOADER_STATS_EN
    , .sets_done(sets_done), .stray_rvalid(stray_rvalid)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  set_t          exp_q[$];
  logic [DW-1:0] word_q[$];
  int            lat_q[$];
  set_t          model_ops = '0;
  int            rq_cnt = 0;
  int            hs_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM model: each read_req pops the next queued word and answers after a chosen latency.
  initial begin
    int            d;
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (nrst && read_req) begin
        check("read_index", samples_loaded_count, rq_cnt[2:0]);
        rq_cnt++;
        if (word_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read_req: count=%0d, no word queued at %0t", samples_loaded_count, $time);
        end else begin
          w = word_q.pop_front();
          d = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(1, 4));
          repeat (d) @(posedge clk);
          #1 resp_valid = 1'b1;
          resp_data = w;
          @(posedge clk);
          #1 resp_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares the presented set with the head of the scoreboard.
  initial begin
    set_t e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (ops_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ops_valid_unexpected: ops_valid=1 with empty scoreboard at %0t", $time);
          end else begin
            e = exp_q[0];
            check("a_real", a_real, e[0]);
            check("a_imag", a_imag, e[1]);
            check("b_real", b_real, e[2]);
            check("b_imag", b_imag, e[3]);
            check("hold_count", samples_loaded_count, 3'd4);
            check("hold_busy", busy, 1'b1);
            if (ops_ready) begin
              check("reads_per_set", rq_cnt, 4);
              model_ops = exp_q.pop_front();
              rq_cnt = 0;
              hs_total++;
              $display("set %0d accepted: %h %h %h %h", hs_total, e[0], e[1], e[2], e[3]);
            end
          end
        end else if (!busy) begin
          check("idle_a_real", a_real, model_ops[0]);
          check("idle_a_imag", a_imag, model_ops[1]);
          check("idle_b_real", b_real, model_ops[2]);
          check("idle_b_imag", b_imag, model_ops[3]);
          check("idle_count", samples_loaded_count, 3'd4);
          check("idle_read_req", read_req, 1'b0);
        end
      end
    end
  end

  task automatic push_set(input set_t s, input int l0, input int l1, input int l2, input int l3);
    exp_q.push_back(s);
    for (int i = 0; i < 4; i++) word_q.push_back(s[i]);
    lat_q.push_back(l0);
    lat_q.push_back(l1);
    lat_q.push_back(l2);
    lat_q.push_back(l3);
  endtask

  task automatic push_random();
    set_t s;
    for (int i = 0; i < 4; i++) s[i] = DW'($urandom_range(0, 65535));
    push_set(s, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until ops_valid; optionally pokes start while loading (must be ignored).
  task automatic wait_valid(input bit poke, output int cycles);
    cycles = 0;
    while (!ops_valid && cycles < 400) begin
      @(posedge clk);
      #1 cycles++;
      start = poke && (cycles % 3 == 1) && !ops_valid;
    end
    start = 1'b0;
    check("ops_valid_timeout", ops_valid, 1'b1);
  endtask

  task automatic accept(input int hold, input bit next);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    check("ops_valid_held", ops_valid, 1'b1);
    ops_ready = 1'b1;
    start = next;
    @(posedge clk);
    #1 ops_ready = 1'b0;
    start = 1'b0;
    check("after_hs_valid", ops_valid, 1'b0);
    if (next) begin
      check("b2b_count", samples_loaded_count, 3'd0);
      check("b2b_busy", busy, 1'b1);
    end else begin
      check("after_hs_busy", busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    bit   found;
    bit   chained;
    set_t s;

    // Reset state while nrst is low
    #12;
    check("rst_count", samples_loaded_count, 3'd4);
    check("rst_read_req", read_req, 1'b0);
    check("rst_ops_valid", ops_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_a_real", a_real, 16'h0);
    check("rst_b_imag", b_imag, 16'h0);
    @(posedge clk);
    #3 nrst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle20_count", samples_loaded_count, 3'd4);
    check("idle20_busy", busy, 1'b0);
`ifdef BFLY_LOADER_STATS_EN
    check("stats_rst_sets", sets_done, 16'd0);
    check("stats_rst_stray", stray_rvalid, 1'b0);
`endif

    // Single set, one-cycle read latency: 12 cycles start to ops_valid
    s = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    push_set(s, 1, 1, 1, 1);
    pulse_start();
    wait_valid(1'b0, c);
    check("start_to_valid", c, 12);
    accept(0, 1'b0);

    // Variable latency, ops_valid held for 10 cycles without ready
    s = {16'h4D4D, 16'h3C3C, 16'h2B2B, 16'h1A1A};
    push_set(s, 1, 5, 2, 9);
    pulse_start();
    wait_valid(1'b0, c);
    accept(10, 1'b0);

    // Back-to-back sets; start pokes during the second load are ignored
    push_random();
    pulse_start();
    wait_valid(1'b0, c);
    s = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    push_set(s, 2, 1, 3, 1);
    accept(2, 1'b1);
    wait_valid(1'b1, c);
    accept(1, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("no_queued_start", busy, 1'b0);

    // Stray rvalid in IDLE, then in ADDR
    stray_valid = 1'b1;
    @(posedge clk);
    #1 stray_valid = 1'b0;
    @(posedge clk);
    #1 check("stray_idle_busy", busy, 1'b0);
`ifdef BFLY_LOADER_STATS_EN
    check("stats_stray_set", stray_rvalid, 1'b1);
`endif
    push_random();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stray_valid = 1'b1;
    check("addr_count", samples_loaded_count, 3'd0);
    @(posedge clk);
    #1 stray_valid = 1'b0;
    wait_valid(1'b0, c);
    accept(0, 1'b0);

    // Abort in WAIT with count=2; the late response must be ignored
    push_set({16'h9999, 16'h8888, 16'h7777, 16'h6666}, 1, 1, 9, 1);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1 found = read_req && (samples_loaded_count == 3'd2);
    end
    check("abort_reached_req2", found, 1'b1);
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort_count", samples_loaded_count, 3'd4);
    check("abort_read_req", read_req, 1'b0);
    check("abort_ops_valid", ops_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_a_real", a_real, 16'h0);
    check("abort_a_imag", a_imag, 16'h0);
`ifdef BFLY_LOADER_STATS_EN
    check("stats_abort_stray", stray_rvalid, 1'b0);
    check("stats_abort_sets", sets_done, 16'd0);
`endif
    exp_q.delete();
    word_q.delete();
    lat_q.delete();
    rq_cnt = 0;
    model_ops = '0;
    hs_total = 0;
    @(posedge clk);
    #3 nrst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("late_rvalid_busy", busy, 1'b0);
    check("late_rvalid_count", samples_loaded_count, 3'd4);
    check("late_rvalid_a_real", a_real, 16'h0);

    // Randomised sets, random ready stalls and random chaining
    chained = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (!chained) begin
        push_random();
        pulse_start();
      end
      wait_valid(1'($urandom_range(0, 1)), c);
      chained = (k < 24) && ($urandom_range(0, 1) == 1);
      if (chained) push_random();
      accept($urandom_range(0, 4), chained);
      if (!chained) repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef BFLY_LOADER_STATS_EN
    check("stats_sets_done", sets_done, hs_total[15:0]);
    check("stats_stray_sticky", stray_rvalid, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bfly_operand_loader.md
Name: bfly_operand_loader

Overview:
- Sequences the four SRAM reads for one radix-2 butterfly: real A, imag A, real B, imag B.
- Drives samples_loaded_count into the downstream address selector, which registers the address; captures each returned word.
- Presents the complete operand set to the butterfly datapath with a valid/ready handshake.
- Sits between the FFT control FSM (start) and the butterfly unit (ops_*), alongside the sample SRAM.

Parameters:
DATA_W, 16, width of one SRAM word and of each operand component.

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset, asynchronous, active-low
start  in  1  request one operand set; sampled only in IDLE, or in HOLD when the handshake completes
sram_rdata  in  DATA_W  read data from sample SRAM
sram_rvalid  in  1  sram_rdata valid this cycle; one pulse per read_req, in order
samples_loaded_count  out  3  word index: 0=real A, 1=imag A, 2=real B, 3=imag B; 4 = none/idle
read_req  out  1  one-cycle SRAM read strobe
busy  out  1  high in every state except IDLE
ops_valid  out  1  operand set complete and stable
ops_ready  in  1  butterfly accepts the set
a_real, a_imag, b_real, b_imag  out  DATA_W each  captured operands

Behaviour:
- Reset (nrst low, async): state=IDLE, samples_loaded_count=4, read_req=0, ops_valid=0, busy=0, all operand outputs=0.
- All outputs are registered.
- States: IDLE, ADDR, REQ, WAIT, HOLD.
- IDLE: on start=1, go to ADDR with count=0. Otherwise hold count=4.
- ADDR: one cycle. Gives the downstream address register time to load the address for the current count. Go to REQ.
- REQ: read_req=1 for exactly one cycle. Go to WAIT.
- WAIT: read_req=0. On sram_rvalid=1, write sram_rdata into the operand register selected by count (0 a_real, 1 a_imag, 2 b_real, 3 b_imag).
  - If count<3: count+1, go to ADDR.
  - If count==3: count=4, go to HOLD.
- sram_rvalid is sampled only in WAIT; assertions in any other state are ignored. Read latency is unbounded, ≥1 cycle after read_req.
- Throughput: minimum 3 cycles per word (ADDR, REQ, WAIT with rvalid on the first WAIT cycle), so 12 cycles start→ops_valid.
- HOLD: ops_valid=1 and operands stable.
  - On ops_ready=1: ops_valid drops the next cycle.
  - If start=1 in the same cycle: go to ADDR with count=0 (back-to-back sets).
  - Otherwise: go to IDLE.
- Operands are overwritten only by the capture of a new set; their values persist through IDLE.
- start while busy and not in a HOLD handshake cycle: ignored (not queued).
- ops_ready outside HOLD: ignored.
- Reset mid-operation: immediate return to reset values; a pending SRAM response after reset deasserts is ignored because the FSM is in IDLE.
- Count is never 5–7. Debug assertion: count ≤4.

Optional Feature:
Macro BFLY_LOADER_STATS_EN.
- Defined: adds output sets_done [15:0], reset 0. Increments on each HOLD handshake (ops_valid & ops_ready) and wraps 0xFFFF→0. Adds output stray_rvalid (1-bit, sticky until reset), set when sram_rvalid=1 outside WAIT.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle: nrst low mid-cycle -> count=4, read_req=0, ops_valid=0 immediately; outputs hold with start=0 for 20 cycles.
- Single set, 1-cycle latency: start pulse, rdata 0x0011/0x0022/0x0033/0x0044 one cycle after each read_req -> count sequence 0,1,2,3,4; exactly 4 read_req pulses; ops_valid on cycle 12 after start; a_real=0x0011, a_imag=0x0022, b_real=0x0033, b_imag=0x0044.
- Variable latency: rvalid delayed 1, 5, 2, 9 cycles -> correct capture order and no extra read_req; ops_valid held with ops_ready=0 for 10 cycles, operands unchanged.
- Back-to-back: ops_ready=1 and start=1 in the same HOLD cycle with new data 0x0A0A.. -> next cycle ADDR with count=0 and ops_valid=0; second set captured correctly; start pulses during the second load are ignored.
- Stray/abort: rvalid in IDLE and ADDR is ignored; nrst asserted in WAIT with count=2 -> IDLE, count=4; a late rvalid after reset is ignored; operands=0.
- BFLY_LOADER_STATS_EN: 3 handshakes -> sets_done=3; one rvalid in IDLE -> stray_rvalid=1 until nrst.
